// File: rtl/fft32_pkg.sv
// Shared constants, sample type and index helper for the 32-point MDC FFT output stage.
package fft32_pkg;
  localparam int unsigned N_POINTS = 32;
  localparam int unsigned HALF     = 16;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned SAMPLE_W = 9;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] re;
    logic signed [SAMPLE_W-1:0] im;
  } cplx_t;

  function automatic logic [3:0] bitrev4(input logic [3:0] k);
    logic [3:0] r;
    r = '0;
    for (int unsigned i = 0; i < 4; i++) r[i] = k[3-i];
    return r;
  endfunction
endpackage

// File: rtl/fft32_pingpong_ram.sv
// Two-bank, 32-entry-per-bank sample store: two writes per cycle into one bank,
// one combinational read from any bank.
module fft32_pingpong_ram
  import fft32_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 wr_bank,
  input  logic [IDX_W-1:0]     wr_addr_a,
  input  logic [2*WIDTH-1:0]   wr_data_a,
  input  logic [IDX_W-1:0]     wr_addr_b,
  input  logic [2*WIDTH-1:0]   wr_data_b,
  input  logic                 rd_bank,
  input  logic [IDX_W-1:0]     rd_addr,
  output logic [2*WIDTH-1:0]   rd_data
);
  logic [2*WIDTH-1:0] mem [2*N_POINTS];

  // Callers guarantee wr_addr_a and wr_addr_b never collide (upper/lower half).
  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wr_bank, wr_addr_a}] <= wr_data_a;
      mem[{wr_bank, wr_addr_b}] <= wr_data_b;
    end
  end

  assign rd_data = mem[{rd_bank, rd_addr}];
endmodule

// File: rtl/fft32_out_reorder.sv
// FFT output reorder: two-lane bit-reversed beats in, one-lane natural-order
// samples out through a ping-pong frame buffer.
module fft32_out_reorder
  import fft32_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sof,
  input  logic signed [WIDTH-1:0] in_up_re,
  input  logic signed [WIDTH-1:0] in_up_im,
  input  logic signed [WIDTH-1:0] in_lo_re,
  input  logic signed [WIDTH-1:0] in_lo_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im,
  output logic [IDX_W-1:0]        out_index,
  output logic                    out_last,
  output logic                    sync_err
);
  logic               wr_bank;
  logic               rd_bank;
  logic [3:0]         wr_cnt;
  logic [IDX_W-1:0]   rd_cnt;
  logic [1:0]         bank_full;

  logic               accept;
  logic               resync;
  logic               wr_done;
  logic               xfer;
  logic               rd_done;
  logic [3:0]         beat_k;
  logic [1:0]         set_mask;
  logic [1:0]         clr_mask;
  logic [2*WIDTH-1:0] rd_data;

  always_comb begin
    in_ready = ~bank_full[wr_bank];
    accept   = in_valid & in_ready;
    // A mid-frame sof restarts the frame: this beat lands as k=0.
    resync   = accept & in_sof & (wr_cnt != '0);
    beat_k   = resync ? '0 : wr_cnt;
    wr_done  = accept & ~resync & (wr_cnt == 4'(HALF-1));

    out_valid = bank_full[rd_bank];
    xfer      = out_valid & out_ready;
    rd_done   = xfer & (rd_cnt == IDX_W'(N_POINTS-1));

    set_mask = '0;
    clr_mask = '0;
    if (wr_done) set_mask[wr_bank] = 1'b1;
    if (rd_done) clr_mask[rd_bank] = 1'b1;

    out_re    = '0;
    out_im    = '0;
    out_index = '0;
    if (out_valid) begin
      out_re    = rd_data[2*WIDTH-1:WIDTH];
      out_im    = rd_data[WIDTH-1:0];
      out_index = rd_cnt;
    end
    out_last = out_valid & (rd_cnt == IDX_W'(N_POINTS-1));
  end

  fft32_pingpong_ram #(.WIDTH(WIDTH)) u_ram (
    .clk       (clk),
    .we        (accept),
    .wr_bank   (wr_bank),
    .wr_addr_a ({1'b0, bitrev4(beat_k)}),
    .wr_data_a ({in_up_re, in_up_im}),
    .wr_addr_b ({1'b1, bitrev4(beat_k)}),
    .wr_data_b ({in_lo_re, in_lo_im}),
    .rd_bank   (rd_bank),
    .rd_addr   (rd_cnt),
    .rd_data   (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      bank_full <= '0;
      sync_err  <= 1'b0;
    end else begin
      if (accept) begin
        if (resync) begin
          wr_cnt <= 4'd1;
        end else if (wr_done) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + 4'd1;
        end
      end
      if (xfer) begin
        if (rd_done) begin
          rd_cnt  <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_cnt <= rd_cnt + 5'd1;
        end
      end
      bank_full <= (bank_full | set_mask) & ~clr_mask;
      sync_err  <= resync;
    end
  end
endmodule

// File: tb/tb_fft32_out_reorder.sv
// Directed bench for fft32_out_reorder: reorder, back-to-back, stall, resync,
// mid-drain reset and extreme sample values.
module tb_fft32_out_reorder;
  localparam int W = 9;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic                in_sof;
  logic signed [W-1:0] in_up_re, in_up_im, in_lo_re, in_lo_im;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_re, out_im;
  logic [4:0]          out_index;
  logic                out_last;
  logic                sync_err;

  always #5 clk = ~clk;

  fft32_out_reorder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_up_re  (in_up_re),
    .in_up_im  (in_up_im),
    .in_lo_re  (in_lo_re),
    .in_lo_im  (in_lo_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_index (out_index),
    .out_last  (out_last),
    .sync_err  (sync_err)
  );

  int total = 0;
  int bad   = 0;

  logic signed [W-1:0] frame_re [32];
  logic signed [W-1:0] frame_im [32];
  logic signed [W-1:0] got_re   [32];
  logic signed [W-1:0] got_im   [32];
  logic [4:0]          got_idx  [32];
  logic                got_last [32];
  int                  got_n;

  function automatic logic [3:0] rev4(input logic [3:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_up_re = '0;
    in_up_im = '0;
    in_lo_re = '0;
    in_lo_im = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic fill_ramp(input int off);
    for (int n = 0; n < 32; n++) begin
      frame_re[n] = W'(off + n);
      frame_im[n] = W'(-(off + n));
    end
  endtask

  task automatic drive_beat(input int k, input logic sof);
    logic [3:0] rk;
    rk = rev4(4'(k));
    in_valid = 1'b1;
    in_sof   = sof;
    in_up_re = frame_re[rk];
    in_up_im = frame_im[rk];
    in_lo_re = frame_re[16 + int'(rk)];
    in_lo_im = frame_im[16 + int'(rk)];
  endtask

  task automatic send_frame();
    for (int k = 0; k < 16; k++) begin
      int waited;
      waited = 0;
      drive_beat(k, 1'b0);
      while (!in_ready && waited < 200) begin
        tick();
        waited++;
      end
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL send_frame_ready beat=%0d got=%b want=1", k, in_ready);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic drain_capture(input int n, input int budget);
    got_n = 0;
    out_ready = 1'b1;
    for (int c = 0; c < budget && got_n < n; c++) begin
      if (out_valid) begin
        got_re[got_n]   = out_re;
        got_im[got_n]   = out_im;
        got_idx[got_n]  = out_index;
        got_last[got_n] = out_last;
        got_n++;
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_index !== 5'd0) begin bad++; $display("FAIL reset_out_index got=%0d want=0", out_index); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL reset_sync_err got=%b want=0", sync_err); end
    total++; if (out_re !== 9'sd0) begin bad++; $display("FAIL reset_out_re got=%0d want=0", out_re); end
  endtask

  task automatic test_single_frame();
    do_reset();
    fill_ramp(0);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid beat=%0d got=%b want=0", k, out_valid); end
      drive_beat(k, 1'b0);
      tick();
    end
    idle_inputs();
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL single_latency got=%b want=1", out_valid); end
    drain_capture(32, 40);
    total++;
    if (got_n != 32) begin bad++; $display("FAIL single_count got=%0d want=32", got_n); end
    for (int n = 0; n < got_n; n++) begin
      total++;
      if (got_re[n] !== W'(n) || got_im[n] !== W'(-n) || got_idx[n] !== 5'(n) || got_last[n] !== (n == 31)) begin
        bad++;
        $display("FAIL single_sample n=%0d got re=%0d im=%0d idx=%0d last=%b want re=%0d im=%0d idx=%0d last=%b",
                 n, got_re[n], got_im[n], got_idx[n], got_last[n], n, -n, n, n == 31);
      end
    end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL single_after got=%b want=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int p;
    int exp_out;
    do_reset();
    out_ready = 1'b1;
    p = 0;
    exp_out = 0;
    for (int c = 0; c < 116; c++) begin
      logic exp_ready;
      logic exp_valid;
      if (p < 48) begin
        int f;
        logic [3:0] rk;
        f  = p / 16;
        rk = rev4(4'(p % 16));
        in_valid = 1'b1;
        in_up_re = W'(f * 32 + int'(rk));
        in_up_im = W'(-(f * 32 + int'(rk)));
        in_lo_re = W'(f * 32 + 16 + int'(rk));
        in_lo_im = W'(-(f * 32 + 16 + int'(rk)));
      end else begin
        idle_inputs();
      end
      if (c <= 48) begin
        exp_ready = (c < 32) || (c >= 48);
        total++;
        if (in_ready !== exp_ready) begin bad++; $display("FAIL b2b_in_ready cycle=%0d got=%b want=%b", c, in_ready, exp_ready); end
      end
      exp_valid = (c >= 16) && (c < 112);
      total++;
      if (out_valid !== exp_valid) begin bad++; $display("FAIL b2b_out_valid cycle=%0d got=%b want=%b", c, out_valid, exp_valid); end
      if (out_valid) begin
        total++;
        if (out_re !== W'(exp_out) || out_im !== W'(-exp_out) || out_index !== 5'(exp_out % 32) || out_last !== (exp_out % 32 == 31)) begin
          bad++;
          $display("FAIL b2b_sample cycle=%0d got re=%0d idx=%0d last=%b want re=%0d idx=%0d",
                   c, out_re, out_index, out_last, exp_out, exp_out % 32);
        end
        exp_out++;
      end
      if (in_valid && in_ready) p++;
      tick();
    end
    idle_inputs();
    total++;
    if (p != 48) begin bad++; $display("FAIL b2b_beats got=%0d want=48", p); end
    total++;
    if (exp_out != 96) begin bad++; $display("FAIL b2b_samples got=%0d want=96", exp_out); end
  endtask

  task automatic test_stall();
    int e;
    int stalls;
    do_reset();
    fill_ramp(100);
    send_frame();
    e = 0;
    stalls = 0;
    for (int c = 0; c < 60 && e < 32; c++) begin
      out_ready = !(e == 7 && stalls < 5);
      total++;
      if (out_valid !== 1'b1 || out_index !== 5'(e) || out_re !== W'(100 + e) || out_im !== W'(-(100 + e))) begin
        bad++;
        $display("FAIL stall_sample cycle=%0d got v=%b idx=%0d re=%0d im=%0d want v=1 idx=%0d re=%0d im=%0d",
                 c, out_valid, out_index, out_re, out_im, e, 100 + e, -(100 + e));
      end
      if (!out_ready) stalls++;
      else e++;
      tick();
    end
    out_ready = 1'b0;
    total++;
    if (e != 32 || stalls != 5) begin bad++; $display("FAIL stall_count got samples=%0d stalls=%0d want 32 and 5", e, stalls); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_after got=%b want=0", out_valid); end
  endtask

  task automatic test_sof_resync();
    do_reset();
    fill_ramp(200);
    for (int k = 0; k < 5; k++) begin
      drive_beat(k, k == 0);
      tick();
      total++;
      if (sync_err !== 1'b0) begin bad++; $display("FAIL sof_noop beat=%0d got=%b want=0", k, sync_err); end
    end
    fill_ramp(50);
    for (int k = 0; k < 16; k++) begin
      drive_beat(k, k == 0);
      tick();
      if (k < 2) begin
        total++;
        if (sync_err !== (k == 0)) begin bad++; $display("FAIL sof_pulse beat=%0d got=%b want=%b", k, sync_err, k == 0); end
      end
    end
    idle_inputs();
    drain_capture(32, 40);
    total++;
    if (got_n != 32) begin bad++; $display("FAIL sof_count got=%0d want=32", got_n); end
    for (int n = 0; n < got_n; n++) begin
      total++;
      if (got_re[n] !== W'(50 + n) || got_im[n] !== W'(-(50 + n)) || got_idx[n] !== 5'(n)) begin
        bad++;
        $display("FAIL sof_sample n=%0d got re=%0d im=%0d idx=%0d want re=%0d im=%0d", n, got_re[n], got_im[n], got_idx[n], 50 + n, -(50 + n));
      end
    end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL sof_extra_frame got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid_drain();
    int c;
    do_reset();
    fill_ramp(10);
    send_frame();
    fill_ramp(60);
    send_frame();
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_both_full got=%b want=0", in_ready); end
    out_ready = 1'b1;
    c = 0;
    while (!(out_valid && out_index == 5'd10) && c < 40) begin
      tick();
      c++;
    end
    total++;
    if (out_index !== 5'd10 || out_re !== 9'sd20) begin bad++; $display("FAIL mid_reach10 got idx=%0d re=%0d want idx=10 re=20", out_index, out_re); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_in_ready got=%b want=1", in_ready); end
    total++; if (out_index !== 5'd0) begin bad++; $display("FAIL mid_rst_out_index got=%0d want=0", out_index); end
    total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL mid_rst_sync_err got=%b want=0", sync_err); end
    out_ready = 1'b0;
    fill_ramp(120);
    send_frame();
    drain_capture(32, 40);
    total++;
    if (got_n != 32) begin bad++; $display("FAIL mid_fresh_count got=%0d want=32", got_n); end
    for (int n = 0; n < got_n; n++) begin
      total++;
      if (got_re[n] !== W'(120 + n) || got_im[n] !== W'(-(120 + n)) || got_idx[n] !== 5'(n)) begin
        bad++;
        $display("FAIL mid_fresh_sample n=%0d got re=%0d im=%0d idx=%0d want re=%0d", n, got_re[n], got_im[n], got_idx[n], 120 + n);
      end
    end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_stale_bank got=%b want=0", out_valid); end
  endtask

  task automatic test_extremes();
    do_reset();
    for (int n = 0; n < 32; n++) begin
      frame_re[n] = W'(n);
      frame_im[n] = '0;
    end
    frame_re[0]  = -9'sd256;
    frame_im[0]  = 9'sd255;
    frame_re[31] = 9'sd255;
    frame_im[31] = -9'sd256;
    send_frame();
    drain_capture(32, 40);
    total++;
    if (got_n != 32) begin bad++; $display("FAIL ext_count got=%0d want=32", got_n); end
    total++;
    if (got_re[0] !== 9'h100 || got_im[0] !== 9'h0FF || got_idx[0] !== 5'd0) begin
      bad++; $display("FAIL ext_bin0 got re=%0d im=%0d idx=%0d want re=-256 im=255 idx=0", got_re[0], got_im[0], got_idx[0]);
    end
    total++;
    if (got_re[31] !== 9'h0FF || got_im[31] !== 9'h100 || got_idx[31] !== 5'd31 || got_last[31] !== 1'b1) begin
      bad++; $display("FAIL ext_bin31 got re=%0d im=%0d idx=%0d last=%b want re=255 im=-256 idx=31 last=1",
                      got_re[31], got_im[31], got_idx[31], got_last[31]);
    end
    for (int n = 1; n < 31; n++) begin
      total++;
      if (got_re[n] !== W'(n) || got_im[n] !== 9'sd0) begin
        bad++; $display("FAIL ext_mid n=%0d got re=%0d im=%0d want re=%0d im=0", n, got_re[n], got_im[n], n);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_sof_resync();
    test_reset_mid_drain();
    test_extremes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
